// File: rtl/rv32_alu_core.sv
// ---------------------------------------------------------------------------
// rv32_alu_core
//   RV32I integer ALU with a purely combinational result path and a single
//   registered copy of that result.
//
//   Optional feature macro: RV32_ALU_ZERO_FLAG_EN
//     defined   -> zero_out = (result_out == 0), combinational
//     undefined -> zero_out tied low, no comparator built
//
// Ports
//   clk_in          in   1   clock, rising-edge active
//   rst_in          in   1   asynchronous active-high reset (clears result_reg_out)
//   op_1_in         in  32   operand A (rs1)
//   op_2_in         in  32   operand B (rs2 or immediate)
//   opcode          in   4   {funct7[5], funct3[2:0]}
//   result_out      out 32   combinational ALU result
//   result_reg_out  out 32   result_out registered, one cycle latency
//   zero_out        out  1   result_out == 0 (see macro above)
// ---------------------------------------------------------------------------
module rv32_alu_core (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] op_1_in,
  input  logic [31:0] op_2_in,
  input  logic [3:0]  opcode,
  output logic [31:0] result_out,
  output logic [31:0] result_reg_out,
  output logic        zero_out
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;

  // Only the low five bits of operand B form the shift amount.
  logic [4:0]  shamt;
  logic        lt_signed;
  logic        lt_unsigned;
  logic [31:0] result_reg_q;

  assign shamt       = op_2_in[4:0];
  assign lt_signed   = $signed(op_1_in) < $signed(op_2_in);
  assign lt_unsigned = op_1_in < op_2_in;

  always_comb begin
    result_out = 32'd0;
    case (opcode)
      OpAdd:   result_out = op_1_in + op_2_in;
      OpSub:   result_out = op_1_in - op_2_in;
      OpSll:   result_out = op_1_in << shamt;
      OpSlt:   result_out = {31'd0, lt_signed};
      OpSltu:  result_out = {31'd0, lt_unsigned};
      OpXor:   result_out = op_1_in ^ op_2_in;
      OpSrl:   result_out = op_1_in >> shamt;
      OpSra:   result_out = $unsigned($signed(op_1_in) >>> shamt);
      OpOr:    result_out = op_1_in | op_2_in;
      OpAnd:   result_out = op_1_in & op_2_in;
      // Unassigned encodings produce a clean zero.
      default: result_out = 32'd0;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      result_reg_q <= 32'd0;
    end else begin
      result_reg_q <= result_out;
    end
  end

  assign result_reg_out = result_reg_q;

`ifdef RV32_ALU_ZERO_FLAG_EN
  assign zero_out = (result_out == 32'd0);
`else
  assign zero_out = 1'b0;
`endif

endmodule

// File: tb/tb_rv32_alu_core.sv
module tb_rv32_alu_core;

  logic        clk;
  logic        rst;
  logic [31:0] op_1;
  logic [31:0] op_2;
  logic [3:0]  opcode;
  logic [31:0] result;
  logic [31:0] result_reg;
  logic        zero;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];

  rv32_alu_core dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .op_1_in        (op_1),
    .op_2_in        (op_2),
    .opcode         (opcode),
    .result_out     (result),
    .result_reg_out (result_reg),
    .zero_out       (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic longint as_signed(input logic [31:0] v);
    longint r;
    r = longint'(v);
    if (v[31]) r = r - 64'sd4294967296;
    return r;
  endfunction

  // Behavioural model built from arithmetic definitions of each operation.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb, pw, q;
    longint unsigned ua, ub, r;
    int sh;
    sh = int'(b % 32);
    ua = longint'(a);
    ub = longint'(b);
    sa = as_signed(a);
    sb = as_signed(b);
    pw = longint'(64'd1 << sh);
    r  = 0;
    case (op)
      4'd0:  r = ua + ub;
      4'd8:  r = ua + 64'h1_0000_0000 - ub;
      4'd1:  r = ua * longint'(pw);
      4'd2:  r = (sa < sb) ? 1 : 0;
      4'd3:  r = (ua < ub) ? 1 : 0;
      4'd4:  r = ua ^ ub;
      4'd5:  r = ua / longint'(pw);
      4'd13: begin
        // Floor division by 2^sh.
        if (sa >= 0) q = sa / pw;
        else q = (sa - (pw - 1)) / pw;
        r = longint'(q);
      end
      4'd6:  r = ua | ub;
      4'd7:  r = ua & ub;
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  // Drive one vector, check the combinational outputs, queue the registered one.
  task automatic apply(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] exp;
    @(negedge clk);
    opcode = op;
    op_1   = a;
    op_2   = b;
    #1;
    exp = ref_alu(op, a, b);
    check($sformatf("result op=%h a=%h b=%h", op, a, b), result, exp);
`ifdef RV32_ALU_ZERO_FLAG_EN
    check($sformatf("zero op=%h a=%h b=%h", op, a, b), {31'd0, zero}, {31'd0, exp == 32'd0});
`else
    check($sformatf("zero op=%h a=%h b=%h", op, a, b), {31'd0, zero}, 32'd0);
`endif
    exp_q.push_back(exp);
  endtask

  task automatic directed(input string name, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] want);
    apply(op, a, b);
    check(name, result, want);
  endtask

  // Monitor: the registered output is presented every rising edge out of reset.
  always @(posedge clk) begin
    #1;
    if (!rst && exp_q.size() > 0) begin
      check("result_reg", result_reg, exp_q.pop_front());
    end
  end

  initial begin
    logic [3:0]  op;
    logic [31:0] a, b;
    rst    = 1'b1;
    op_1   = 32'd0;
    op_2   = 32'd0;
    opcode = 4'd0;
    #1;
    check("reset result_reg", result_reg, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    directed("add 15+10",   4'b0000, 32'd15, 32'd10, 32'd25);
    directed("sub 15-10",   4'b1000, 32'd15, 32'd10, 32'd5);
    directed("sub 0-1",     4'b1000, 32'd0,  32'd1,  32'hFFFF_FFFF);
    directed("srl 8>>2",    4'b0101, 32'd8,  32'd2,  32'd2);
    directed("sra",         4'b1101, 32'hFFFF_FFF8, 32'd2, 32'hFFFF_FFFE);
    directed("sll 6<<3",    4'b0001, 32'd6,  32'd3,  32'd48);
    directed("sll 1<<33",   4'b0001, 32'd1,  32'd33, 32'd2);
    directed("slt 5,10",    4'b0010, 32'd5,  32'd10, 32'd1);
    directed("slt -1,1",    4'b0010, 32'hFFFF_FFFF, 32'd1, 32'd1);
    directed("sltu 5,10",   4'b0011, 32'd5,  32'd10, 32'd1);
    directed("sltu max,1",  4'b0011, 32'hFFFF_FFFF, 32'd1, 32'd0);
    directed("or",          4'b0110, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    directed("xor",         4'b0100, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'hFFFF_FFFF);
    directed("and",         4'b0111, 32'hF0F0_F0F0, 32'h0F0F_0F0F, 32'd0);
    directed("unassigned",  4'b1111, 32'h1234_5678, 32'h9ABC_DEF0, 32'd0);

    for (int i = 0; i < 300; i++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = (i % 3 == 0) ? 32'($urandom_range(0, 63)) : $urandom;
      if (i % 7 == 0) b = a;
      apply(op, a, b);
    end

    // Asynchronous reset mid-cycle with a settled ADD on the inputs.
    directed("add before reset", 4'b0000, 32'd15, 32'd10, 32'd25);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("async reset result_reg", result_reg, 32'd0);
    check("result during reset", result, 32'd25);
    @(negedge clk);
    @(negedge clk);
    check("held in reset", result_reg, 32'd0);
    rst = 1'b0;
    exp_q.push_back(32'd25);
    @(posedge clk);
    #2;
    check("first edge after reset", result_reg, 32'd25);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d outputs still pending, required 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
